// File: rtl/aes_key_schedule_pkg.sv
// Shared types and helpers for the AES key schedule: S-box, key-length decode, xtime.
package aes_key_schedule_pkg;

    localparam logic [1:0] KL_128 = 2'b00;
    localparam logic [1:0] KL_192 = 2'b10;
    localparam logic [1:0] KL_256 = 2'b11;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_EXPAND = 1'b1
    } ks_state_t;

    typedef struct packed {
        logic [3:0] nk;
        logic [3:0] nr;
    } ks_len_t;

    function automatic ks_len_t ks_len(input logic [1:0] kl);
        ks_len_t l;
        case (kl)
            KL_192:  begin l.nk = 4'd6; l.nr = 4'd12; end
            KL_256:  begin l.nk = 4'd8; l.nr = 4'd14; end
            default: begin l.nk = 4'd4; l.nr = 4'd10; end
        endcase
        return l;
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        logic [7:0] bb;
        p  = 8'h00;
        aa = a;
        bb = b;
        for (int k = 0; k < 8; k++) begin
            if (bb[0]) p = p ^ aa;
            aa = xtime(aa);
            bb = bb >> 1;
        end
        return p;
    endfunction

    // S-box as affine(x^254); x^254 is the GF(2^8) inverse and maps 0 to 0.
    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] inv;
        inv = 8'h01;
        for (int k = 7; k >= 0; k--) begin
            inv = gf_mul(inv, inv);
            if (k != 0) inv = gf_mul(inv, x);
        end
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                   ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

endpackage

// File: rtl/aes_key_schedule_sub_word.sv
// 32-bit SubWord: four independent S-box lookups.
module aes_sub_word
    import aes_key_schedule_pkg::*;
(
    input  logic [31:0] word,
    output logic [31:0] sub
);

    always_comb begin
        sub = {sbox(word[31:24]), sbox(word[23:16]), sbox(word[15:8]), sbox(word[7:0])};
    end

endmodule

// File: rtl/aes_key_schedule.sv
// AES key expansion, one word per cycle, with combinational round-key readout.
// Optional macro AES_KS_ZEROIZE_EN adds a zeroize input that clears the word store.
//
// state     | meaning
// ST_IDLE   | no expansion running; round_key valid when key_ready
// ST_EXPAND | writing w[idx] each edge until the last word of the schedule
module aes_key_schedule
    import aes_key_schedule_pkg::*;
#(
    parameter int MAX_WORDS = 60
)
(
    input  logic         clk,
    input  logic         rst,
    input  logic         key_load,
    input  logic [1:0]   key_length,
    input  logic [255:0] cipher_key,
    input  logic [3:0]   round,
`ifdef AES_KS_ZEROIZE_EN
    input  logic         zeroize,
`endif
    output logic [127:0] round_key,
    output logic         key_ready,
    output logic         busy
);

    ks_state_t   state;
    logic [5:0]  idx;
    logic [2:0]  kmod;
    logic [7:0]  rcon;
    logic [3:0]  nk;
    logic [3:0]  nr;
    logic [31:0] w [MAX_WORDS];

    ks_len_t     load_len;
    logic [31:0] prev;
    logic [31:0] back;
    logic [31:0] sub_in;
    logic [31:0] sub_out;
    logic [31:0] temp;
    logic [31:0] new_word;
    logic [5:0]  last_idx;

    assign load_len = ks_len(key_length);
    assign prev     = w[idx - 6'd1];
    assign back     = w[idx - {2'b00, nk}];
    assign sub_in   = (kmod == 3'd0) ? {prev[23:0], prev[31:24]} : prev;
    assign new_word = back ^ temp;
    // 4*(Nr+1)-1
    assign last_idx = {nr, 2'b11};

    aes_sub_word u_sub_word (
        .word (sub_in),
        .sub  (sub_out)
    );

    always_comb begin
        temp = prev;
        if (kmod == 3'd0)
            temp = sub_out ^ {rcon, 24'h000000};
        else if (nk == 4'd8 && kmod == 3'd4)
            temp = sub_out;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            key_ready <= 1'b0;
            busy      <= 1'b0;
            idx       <= 6'd0;
            kmod      <= 3'd0;
            rcon      <= 8'h01;
            nk        <= 4'd4;
            nr        <= 4'd10;
`ifdef AES_KS_ZEROIZE_EN
        end else if (zeroize) begin
            state     <= ST_IDLE;
            key_ready <= 1'b0;
            busy      <= 1'b0;
`endif
        end else if (key_load) begin
            nk        <= load_len.nk;
            nr        <= load_len.nr;
            idx       <= {2'b00, load_len.nk};
            kmod      <= 3'd0;
            rcon      <= 8'h01;
            key_ready <= 1'b0;
            busy      <= 1'b1;
            state     <= ST_EXPAND;
        end else if (state == ST_EXPAND) begin
            idx  <= idx + 6'd1;
            // nk[2:0]-1 wraps to 7 for Nk=8
            kmod <= (kmod == nk[2:0] - 3'd1) ? 3'd0 : kmod + 3'd1;
            if (kmod == 3'd0) rcon <= xtime(rcon);
            if (idx == last_idx) begin
                state     <= ST_IDLE;
                key_ready <= 1'b1;
                busy      <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
`ifdef AES_KS_ZEROIZE_EN
        if (rst || zeroize) begin
            for (int j = 0; j < MAX_WORDS; j++) w[j] <= '0;
        end else
`endif
        if (!rst && key_load) begin
            for (int j = 0; j < 8; j++)
                if (j < int'(load_len.nk)) w[j] <= cipher_key[255 - 32*j -: 32];
        end else if (!rst && state == ST_EXPAND) begin
            w[idx] <= new_word;
        end
    end

    always_comb begin
        round_key = '0;
        if (key_ready && round <= nr)
            round_key = {w[{round, 2'b00}], w[{round, 2'b01}], w[{round, 2'b10}], w[{round, 2'b11}]};
    end

endmodule

// File: tb/tb_aes_key_schedule.sv
// Scoreboard bench for aes_key_schedule: FIPS-197 vectors plus random keys against a reference model.
module tb_aes_key_schedule;

    logic         clk = 1'b0;
    logic         rst;
    logic         key_load;
    logic [1:0]   key_length;
    logic [255:0] cipher_key;
    logic [3:0]   round;
    logic [127:0] round_key;
    logic         key_ready;
    logic         busy;
`ifdef AES_KS_ZEROIZE_EN
    logic         zeroize = 1'b0;
`endif

    always #5 clk = ~clk;

    aes_key_schedule dut (
        .clk        (clk),
        .rst        (rst),
        .key_load   (key_load),
        .key_length (key_length),
        .cipher_key (cipher_key),
        .round      (round),
`ifdef AES_KS_ZEROIZE_EN
        .zeroize    (zeroize),
`endif
        .round_key  (round_key),
        .key_ready  (key_ready),
        .busy       (busy)
    );

    localparam logic [127:0] K128 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [191:0] K192 = 192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b;
    localparam logic [255:0] K256 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;

    typedef struct {
        logic [127:0] rk;
        logic         rdy;
        logic         bsy;
    } probe_t;

    int          checks = 0;
    int          passed = 0;
    int          cyc = 0;
    int          load_cyc = 0;
    logic        ready_d = 1'b0;
    int          lat_q[$];
    probe_t      rk_q[$];
    string       name_q[$];
    logic [7:0]  sb [256];
    logic [31:0] ref_w [60];

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h, expected %h", nm, act, exp);
    endtask

    // S-box generated by walking the multiplicative group (p *= 3, q /= 3).
    task automatic build_sbox();
        logic [7:0] p;
        logic [7:0] q;
        logic [7:0] x;
        p = 8'h01;
        q = 8'h01;
        do begin
            p = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
            q = q ^ {q[6:0], 1'b0};
            q = q ^ {q[5:0], 2'b00};
            q = q ^ {q[3:0], 4'h0};
            if (q[7]) q = q ^ 8'h09;
            x = q ^ {q[6:0], q[7]} ^ {q[5:0], q[7:6]} ^ {q[4:0], q[7:5]} ^ {q[3:0], q[7:4]};
            sb[p] = x ^ 8'h63;
        end while (p != 8'h01);
        sb[0] = 8'h63;
    endtask

    function automatic logic [31:0] subw(input logic [31:0] v);
        return {sb[v[31:24]], sb[v[23:16]], sb[v[15:8]], sb[v[7:0]]};
    endfunction

    function automatic int nk_of(input logic [1:0] kl);
        return (kl == 2'b10) ? 6 : (kl == 2'b11) ? 8 : 4;
    endfunction

    function automatic int lat_of(input logic [1:0] kl);
        return (kl == 2'b10) ? 46 : (kl == 2'b11) ? 52 : 40;
    endfunction

    task automatic ref_expand(input logic [255:0] key, input logic [1:0] kl);
        int nk;
        int total;
        logic [31:0] t;
        logic [7:0]  rc;
        nk    = nk_of(kl);
        total = 4 * (nk + 7);
        rc    = 8'h01;
        for (int i = 0; i < nk; i++) ref_w[i] = key[255 - 32*i -: 32];
        for (int i = nk; i < total; i++) begin
            t = ref_w[i-1];
            if (i % nk == 0) begin
                t  = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
                rc = {rc[6:0], 1'b0} ^ (rc[7] ? 8'h1b : 8'h00);
            end else if (nk == 8 && i % 8 == 4) begin
                t = subw(t);
            end
            ref_w[i] = ref_w[i-nk] ^ t;
        end
    endtask

    function automatic logic [127:0] ref_rk(input int r);
        return {ref_w[4*r], ref_w[4*r+1], ref_w[4*r+2], ref_w[4*r+3]};
    endfunction

    // Drive a load at the next edge; scramble key inputs afterwards to prove they are latched.
    task automatic do_load(input logic [1:0] kl, input logic [255:0] key);
        key_length = kl;
        cipher_key = key;
        key_load   = 1'b1;
        @(posedge clk);
        #1;
        key_load   = 1'b0;
        key_length = 2'($urandom_range(0, 3));
        cipher_key = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    endtask

    task automatic load_expect(input logic [1:0] kl, input logic [255:0] key);
        ref_expand(key, kl);
        lat_q.push_back(lat_of(kl));
        do_load(kl, key);
    endtask

    task automatic wait_ready(input string nm);
        int n;
        n = 0;
        while (!key_ready && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (!key_ready) begin
            checks++;
            $display("FAIL %s: key_ready still 0 after %0d cycles, expected 1", nm, n);
        end
    endtask

    task automatic probe(input string nm, input logic [3:0] r, input logic [127:0] rk,
                         input logic rdy, input logic bsy);
        probe_t p;
        round = r;
        p.rk  = rk;
        p.rdy = rdy;
        p.bsy = bsy;
        rk_q.push_back(p);
        name_q.push_back(nm);
        @(posedge clk);
        #1;
    endtask

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (key_load && !rst) load_cyc <= cyc + 1;
    end

    always @(negedge clk) begin
        probe_t p;
        string  nm;
        int     exp_lat;
        checks++;
        if (!(key_ready && busy)) passed++;
        else $display("FAIL ready_busy_excl: got ready=1 busy=1, expected not both");
        if (key_ready && !ready_d) begin
            if (lat_q.size() == 0) begin
                checks++;
                $display("FAIL unexpected_ready: got rise at cycle %0d, expected none", cyc);
            end else begin
                exp_lat = lat_q.pop_front();
                chk("latency", 128'(cyc - load_cyc), 128'(exp_lat));
            end
        end
        ready_d <= key_ready;
        while (rk_q.size() > 0) begin
            p  = rk_q.pop_front();
            nm = name_q.pop_front();
            chk(nm, round_key, p.rk);
            chk({nm, "_flags"}, {126'h0, key_ready, busy}, {126'h0, p.rdy, p.bsy});
        end
    end

    initial begin
        int         nr;
        logic [1:0] kl;
        build_sbox();
        rst        = 1'b1;
        key_load   = 1'b0;
        key_length = 2'b00;
        cipher_key = '0;
        round      = 4'd0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        probe("reset", 4'd0, 128'h0, 1'b0, 1'b0);

        load_expect(2'b00, {K128, 128'h0});
        wait_ready("aes128_ready");
        probe("aes128_r0", 4'd0, K128, 1'b1, 1'b0);
        probe("aes128_r1", 4'd1, 128'ha0fafe1788542cb123a339392a6c7605, 1'b1, 1'b0);
        probe("aes128_r10", 4'd10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6, 1'b1, 1'b0);
        probe("aes128_r11", 4'd11, 128'h0, 1'b1, 1'b0);

        load_expect(2'b10, {K192, 64'h0});
        wait_ready("aes192_ready");
        probe("aes192_r12", 4'd12, 128'he98ba06f448c773c8ecc720401002202, 1'b1, 1'b0);
        probe("aes192_r13", 4'd13, 128'h0, 1'b1, 1'b0);

        load_expect(2'b11, K256);
        wait_ready("aes256_ready");
        probe("aes256_r14", 4'd14, 128'hfe4890d1e6188d0b046df344706c631e, 1'b1, 1'b0);
        probe("aes256_r15", 4'd15, 128'h0, 1'b1, 1'b0);

        // Restart a 256-bit expansion with a 128-bit key ten edges in.
        do_load(2'b11, K256);
        repeat (9) @(posedge clk);
        #1;
        load_expect(2'b00, {K128, 128'h0});
        wait_ready("reload_ready");
        probe("reload_r10", 4'd10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6, 1'b1, 1'b0);

        // Synchronous reset twenty edges into a 128-bit expansion.
        do_load(2'b00, {K128, 128'h0});
        repeat (19) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        probe("rst_mid", 4'd0, 128'h0, 1'b0, 1'b0);
        repeat (50) @(posedge clk);
        #1;
        probe("rst_idle", 4'd1, 128'h0, 1'b0, 1'b0);
        load_expect(2'b00, {K128, 128'h0});
        wait_ready("post_rst_ready");
        probe("post_rst_r10", 4'd10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6, 1'b1, 1'b0);

        for (int t = 0; t < 6; t++) begin
            kl = 2'($urandom_range(0, 3));
            load_expect(kl, {$urandom, $urandom, $urandom, $urandom,
                             $urandom, $urandom, $urandom, $urandom});
            probe("rand_loading", 4'd0, 128'h0, 1'b0, 1'b1);
            wait_ready("rand_ready");
            nr = nk_of(kl) + 6;
            for (int r = 0; r <= nr; r++) probe("rand_rk", 4'(r), ref_rk(r), 1'b1, 1'b0);
            if (nr < 15) probe("rand_beyond_nr", 4'(nr + 1), 128'h0, 1'b1, 1'b0);
        end

        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (lat_q.size() == 0) passed++;
        else $display("FAIL pending_ready: got %0d loads without key_ready, expected 0", lat_q.size());
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/aes_key_schedule.md
Name: aes_key_schedule

Overview:
- Round-key provider for aes_core. Sits on the other end of the core's round/round_key interface.
- Accepts a 128/192/256-bit cipher key and expands it one 32-bit word per cycle into an internal word store, per FIPS-197 KeyExpansion.
- After expansion, combinationally returns the 128-bit round key for the round index driven by aes_core.
- aes_core already reverses the index for decryption, so this block only indexes forward.

Parameters:
- MAX_WORDS, 60, depth of the word store; 4*(14+1), sized for AES-256.

Ports:
- clk  input  1  clock
- rst  input  1  synchronous, active-high reset
- key_load  input  1  start expansion; samples cipher_key and key_length
- key_length  input  2  2'b10 = 192, 2'b11 = 256, 2'b00/2'b01 = 128 (same encoding as aes_core)
- cipher_key  input  256  key, MSB-aligned: 128 in [255:128], 192 in [255:64], 256 in [255:0]; w[0] = [255:224]
- round  input  4  round index from aes_core
- round_key  output  128  {w[4r], w[4r+1], w[4r+2], w[4r+3]}, w[4r] in the MSBs
- key_ready  output  1  expansion complete, round_key valid
- busy  output  1  expansion in progress

Behaviour:
- Per key length: Nk = 4/6/8, Nr = 10/12/14, total words = 44/52/60.
- States: IDLE, EXPAND.
- Reset: state IDLE, key_ready=0, busy=0, word index=0, Rcon=8'h01. Word store is not reset.
- key_load in any state, including EXPAND: at that edge
  - latch Nk/Nr from key_length;
  - write w[0..Nk-1] from cipher_key;
  - i <= Nk, Rcon <= 8'h01;
  - key_ready <= 0, state <= EXPAND.
  - A load during EXPAND aborts the current expansion and restarts. key_load has priority over the expansion step in that cycle.
- EXPAND, one word per edge: temp = w[i-1].
  - If i mod Nk == 0: temp = SubWord(RotWord(temp)) ^ {Rcon, 24'h0}, then Rcon <= xtime(Rcon).
  - Else if Nk == 8 and i mod 8 == 4: temp = SubWord(temp).
  - w[i] <= w[i-Nk] ^ temp.
  - i mod Nk is tracked by a separate 0..Nk-1 counter; no divider.
- Termination: at the edge writing the last word (i = total-1), state <= IDLE and key_ready <= 1.
- Latency: key_ready rises 40/46/52 edges after the key_load edge (128/192/256).
- busy = (state == EXPAND). key_ready and busy are never both 1.
- round_key: combinational from round.
  - 128'h0 when key_ready=0.
  - 128'h0 when round > latched Nr.
  - Otherwise the stored words.
- key_length and cipher_key changes after the load edge are ignored until the next key_load.
- rst during EXPAND: returns to IDLE with key_ready=0 on that edge. No further words are written.

Optional Feature:
- Macro: AES_KS_ZEROIZE_EN.
- Defined:
  - Adds input zeroize (1 bit).
  - When zeroize is asserted (not during rst), all MAX_WORDS words clear to 0 on that edge, key_ready <= 0, state <= IDLE.
  - zeroize has priority over key_load.
  - rst also clears the store.
- Undefined:
  - Port absent.
  - Store contents persist across rst and reloads.

Decomposition:
- function_package holds:
  - existing sbox function;
  - key_length encodings as localparams (KL_128, KL_192, KL_256);
  - Nk/Nr lookup function;
  - xtime function.
- One sub-module: aes_sub_word (32-bit SubWord, four sbox lookups). It is used on the single expansion datapath.

Test Plan:
- AES-128, key 2b7e151628aed2a6abf7158809cf4f3c, load:
  - key_ready rises exactly 40 cycles after the load edge;
  - round=0 gives the key itself;
  - round=1 gives a0fafe1788542cb123a339392a6c7605;
  - round=10 gives d014f9a8c9ee2589e13f0cc8b6630ca6;
  - round=11 gives 0.
- AES-192, key 8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b:
  - ready after 46 cycles;
  - round=12 gives e98ba06f448c773c8ecc720401002202.
- AES-256, key 603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4:
  - ready after 52 cycles;
  - round=14 gives fe4890d1e6188d0b046df344706c631e.
- Reload mid-expansion: start the 256 load, issue the 128 load 10 cycles later.
  - key_ready stays 0 throughout;
  - ready 40 cycles after the second load;
  - round=10 gives the AES-128 vector above.
- rst at cycle 20 of a 128 expansion:
  - key_ready=0, busy=0 next cycle;
  - round_key=0;
  - a subsequent load completes normally.
- Integration: aes_core plus this block, encrypt plaintext 3243f6a8885a308d313198a2e0370734 with the 128 key above.
  - aes_out = 3925841d02dc09fbdc118597196a0b32;
  - decrypting that ciphertext returns the plaintext.
